inverter_scheduler: RTL and testbench

INVERTER_SCHEDULER -- requirements
Module: inverter_scheduler

---
 rtl/inverter_scheduler.sv | 109 ++++++++++
 tb/tb_inverter_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverter_scheduler.sv
// rtl/inverter_scheduler.sv - round-robin issue scheduler for a shared pipelined masked GF(16) inverter
//
// Ports:
//   ClkxCI, RstxBI                 clock, asynchronous active-low reset
//   ReqnValidxSI / _ReqnXxDI       requester n operand (SHARES nibbles, share i at [4i+3:4i])
//   ReqnReadyxSO                   requester n operand taken this cycle
//   RandValidxSI / RandReadyxSO    inverter mask randomness available / consumed
//   _InvXxDO / _InvQxDI            operand to the inverter / result from the inverter
//   RspValidxSO, RspIdxDO          result valid and owning requester
//   _RspQxDO                       shared result nibbles
//   InFlightxDO                    operations issued and not yet returned
module inverter_scheduler #(
  parameter int SHARES  = 2,
  parameter int LATENCY = 3
) (
  input  logic                  ClkxCI,
  input  logic                  RstxBI,
  input  logic                  Req0ValidxSI,
  input  logic                  Req1ValidxSI,
  input  logic [4*SHARES-1:0]   _Req0XxDI,
  input  logic [4*SHARES-1:0]   _Req1XxDI,
  output logic                  Req0ReadyxSO,
  output logic                  Req1ReadyxSO,
  input  logic                  RandValidxSI,
  output logic                  RandReadyxSO,
  output logic [4*SHARES-1:0]   _InvXxDO,
  input  logic [4*SHARES-1:0]   _InvQxDI,
  output logic                  RspValidxSO,
  output logic                  RspIdxDO,
  output logic [4*SHARES-1:0]   _RspQxDO,
  output logic [3:0]            InFlightxDO
);

  localparam int W = 4 * SHARES;

  logic               prio_q, prio_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0] tag_id_q, tag_id_d;
  logic [3:0]         inflight_q, inflight_d;
  logic               issue;
  logic               winner;
  logic               retire;

  // Round-robin pick: the pointer only matters when both requesters contend.
  always_comb begin
    winner = 1'b0;
    if (Req0ValidxSI && Req1ValidxSI) begin
      winner = prio_q;
    end else if (Req1ValidxSI) begin
      winner = 1'b1;
    end
  end

  // Issue needs fresh mask randomness; reset gates it so every combinational
  // output is quiet while RstxBI is low, independent of the request inputs.
  assign issue  = RstxBI & RandValidxSI & (Req0ValidxSI | Req1ValidxSI);
  assign retire = tag_vld_q[LATENCY-1];
  assign prio_d = issue ? ~winner : prio_q;

  // The tag pipe mirrors the inverter pipe exactly; it never stalls.
  // Ids are stored qualified by issue so idle slots stay all-zero.
  generate
    if (LATENCY == 1) begin : g_tag_single
      assign tag_vld_d = issue;
      assign tag_id_d  = issue & winner;
    end else begin : g_tag_multi
      assign tag_vld_d = {tag_vld_q[LATENCY-2:0], issue};
      assign tag_id_d  = {tag_id_q[LATENCY-2:0], issue & winner};
    end
  endgenerate

  // Simultaneous issue and retire leave the count unchanged.
  always_comb begin
    inflight_d = inflight_q;
    if (issue && !retire) begin
      inflight_d = inflight_q + 4'd1;
    end else if (!issue && retire) begin
      inflight_d = inflight_q - 4'd1;
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      prio_q     <= 1'b0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      inflight_q <= 4'd0;
    end else begin
      prio_q     <= prio_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      inflight_q <= inflight_d;
    end
  end

  assign Req0ReadyxSO = issue & ~winner;
  assign Req1ReadyxSO = issue & winner;
  assign RandReadyxSO = issue;

  // The inverter input is zeroed outside issue cycles so no stale shares
  // sit on it while the mask randomness is not being consumed.
  assign _InvXxDO = issue ? (winner ? _Req1XxDI : _Req0XxDI) : {W{1'b0}};

  assign RspValidxSO = retire;
  assign RspIdxDO    = retire & tag_id_q[LATENCY-1];
  assign _RspQxDO    = retire ? _InvQxDI : {W{1'b0}};
  assign InFlightxDO = inflight_q;

endmodule

// File: tb/tb_inverter_scheduler.sv
// tb/tb_inverter_scheduler.sv - self-checking bench for inverter_scheduler with a behavioural inverter
module tb_inverter_scheduler;

  localparam int SHARES  = 2;
  localparam int LATENCY = 3;
  localparam int W       = 4 * SHARES;
  localparam int VW      = 3 + W + 4;

  logic           ClkxCI = 1'b0;
  logic           RstxBI = 1'b1;
  logic           Req0ValidxSI, Req1ValidxSI;
  logic [W-1:0]   _Req0XxDI, _Req1XxDI;
  logic           Req0ReadyxSO, Req1ReadyxSO;
  logic           RandValidxSI, RandReadyxSO;
  logic [W-1:0]   _InvXxDO, _InvQxDI;
  logic           RspValidxSO, RspIdxDO;
  logic [W-1:0]   _RspQxDO;
  logic [3:0]     InFlightxDO;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct packed {
    logic       id;
    logic [3:0] q;
  } exp_t;

  exp_t               sb[$];
  exp_t               mon_e;
  logic               m_prio = 1'b0;
  logic [LATENCY-1:0] m_tag  = '0;
  logic [W-1:0]       inv_pipe [LATENCY];

  inverter_scheduler #(.SHARES(SHARES), .LATENCY(LATENCY)) dut (
    .ClkxCI       (ClkxCI),
    .RstxBI       (RstxBI),
    .Req0ValidxSI (Req0ValidxSI),
    .Req1ValidxSI (Req1ValidxSI),
    ._Req0XxDI    (_Req0XxDI),
    ._Req1XxDI    (_Req1XxDI),
    .Req0ReadyxSO (Req0ReadyxSO),
    .Req1ReadyxSO (Req1ReadyxSO),
    .RandValidxSI (RandValidxSI),
    .RandReadyxSO (RandReadyxSO),
    ._InvXxDO     (_InvXxDO),
    ._InvQxDI     (_InvQxDI),
    .RspValidxSO  (RspValidxSO),
    .RspIdxDO     (RspIdxDO),
    ._RspQxDO     (_RspQxDO),
    .InFlightxDO  (InFlightxDO)
  );

  always #5 ClkxCI = ~ClkxCI;

  // GF(16) with reduction polynomial x^4 + x + 1.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[3] ? ((aa << 1) ^ 4'h3) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    for (int v = 1; v < 16; v++) begin
      if (gf_mul(a, 4'(v)) == 4'h1) return 4'(v);
    end
    return 4'h0;
  endfunction

  function automatic logic [3:0] xor_shares(input logic [W-1:0] s);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < SHARES; i++) r = r ^ s[4*i +: 4];
    return r;
  endfunction

  function automatic logic [W-1:0] mask_shares(input logic [3:0] v);
    logic [W-1:0] s;
    s      = W'($urandom);
    s[3:0] = 4'h0;
    s[3:0] = v ^ xor_shares(s);
    return s;
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {Req0ReadyxSO, Req1ReadyxSO, RandReadyxSO, _InvXxDO, InFlightxDO};
  endfunction

  // Behavioural pipelined masked inverter, re-sharing its result.
  always @(posedge ClkxCI) begin
    inv_pipe[0] <= mask_shares(gf_inv(xor_shares(_InvXxDO)));
    for (int i = 1; i < LATENCY; i++) inv_pipe[i] <= inv_pipe[i-1];
  end
  assign _InvQxDI = inv_pipe[LATENCY-1];

  // Response monitor: pops the scoreboard on every valid response.
  always @(negedge ClkxCI) begin
    if (RspValidxSO) begin
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL rsp_unexpected got id=%0d q=%h want=no response", RspIdxDO, _RspQxDO);
      end else begin
        mon_e = sb.pop_front();
        if ({RspIdxDO, xor_shares(_RspQxDO)} !== {mon_e.id, mon_e.q})
          $display("FAIL rsp_data got id=%0d q=%h want id=%0d q=%h",
                   RspIdxDO, xor_shares(_RspQxDO), mon_e.id, mon_e.q);
        else pass_cnt++;
      end
    end else begin
      chk_cnt++;
      if ({RspIdxDO, _RspQxDO} !== {(W+1){1'b0}})
        $display("FAIL rsp_idle_zero got id=%0d q=%h want 0", RspIdxDO, _RspQxDO);
      else pass_cnt++;
    end
  end

  // Drives one cycle at the falling edge and returns what the reference
  // arbiter expects on the combinational outputs for that cycle.
  task automatic drive_cycle(input logic v0, input logic v1, input logic rv,
                             input logic [W-1:0] x0, input logic [W-1:0] x1,
                             output logic [VW-1:0] exp_vec, output logic win,
                             output logic iss);
    logic [W-1:0] wx;
    exp_t         e;
    @(negedge ClkxCI);
    Req0ValidxSI = v0;
    Req1ValidxSI = v1;
    RandValidxSI = rv;
    _Req0XxDI    = x0;
    _Req1XxDI    = x1;
    #1;
    iss = rv && (v0 || v1);
    win = (v0 && v1) ? m_prio : v1;
    wx  = win ? x1 : x0;
    exp_vec = {iss && !win, iss && win, iss, iss ? wx : {W{1'b0}}, 4'($countones(m_tag))};
    if (iss) begin
      e.id = win;
      e.q  = gf_inv(xor_shares(wx));
      sb.push_back(e);
      m_prio = ~win;
    end
    m_tag = {m_tag[LATENCY-2:0], iss};
  endtask

  task automatic clear_inputs();
    Req0ValidxSI = 1'b0;
    Req1ValidxSI = 1'b0;
    RandValidxSI = 1'b0;
    _Req0XxDI    = '0;
    _Req1XxDI    = '0;
  endtask

  // Release happens just after a rising edge so the next edge can issue.
  task automatic apply_reset();
    @(negedge ClkxCI);
    #2;
    RstxBI = 1'b0;
    clear_inputs();
    sb.delete();
    m_prio = 1'b0;
    m_tag  = '0;
    repeat (2) @(posedge ClkxCI);
    #1;
    RstxBI = 1'b1;
  endtask

  task automatic test_reset();
    RstxBI       = 1'b0;
    Req0ValidxSI = 1'b1;
    Req1ValidxSI = 1'b1;
    RandValidxSI = 1'b1;
    _Req0XxDI    = 8'hA5;
    _Req1XxDI    = 8'h3C;
    @(negedge ClkxCI);
    #1;
    chk_cnt++;
    if ({obs_vec(), RspValidxSO, RspIdxDO, _RspQxDO} !== {(VW+W+2){1'b0}})
      $display("FAIL reset_outputs got %h want 0", {obs_vec(), RspValidxSO, RspIdxDO, _RspQxDO});
    else pass_cnt++;
    clear_inputs();
    @(posedge ClkxCI);
    #1;
    RstxBI = 1'b1;
  endtask

  task automatic test_starvation();
    logic [VW-1:0] ev;
    logic w, iss;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 8'h12, 8'h34, ev, w, iss);
      chk_cnt++;
      if ({Req0ReadyxSO, Req1ReadyxSO, RandReadyxSO, _InvXxDO} !== {(3+W){1'b0}})
        $display("FAIL starve_quiet cyc=%0d got %h want 0", k,
                 {Req0ReadyxSO, Req1ReadyxSO, RandReadyxSO, _InvXxDO});
      else pass_cnt++;
    end
    drive_cycle(1'b1, 1'b1, 1'b1, 8'h12, 8'h34, ev, w, iss);
    chk_cnt++;
    if ({Req0ReadyxSO, Req1ReadyxSO, RandReadyxSO, _InvXxDO} !== {3'b101, 8'h12})
      $display("FAIL starve_release got %h want %h",
               {Req0ReadyxSO, Req1ReadyxSO, RandReadyxSO, _InvXxDO}, {3'b101, 8'h12});
    else pass_cnt++;
  endtask

  task automatic test_drain(input string name);
    logic [VW-1:0] ev;
    logic w, iss;
    repeat (LATENCY + 2) begin
      drive_cycle(1'b0, 1'b0, 1'($urandom), W'($urandom), W'($urandom), ev, w, iss);
      chk_cnt++;
      if (obs_vec() !== ev) $display("FAIL %s_drain_outputs got %h want %h", name, obs_vec(), ev);
      else pass_cnt++;
    end
    chk_cnt++;
    if ({sb.size() == 0, InFlightxDO} !== {1'b1, 4'd0})
      $display("FAIL %s_drained got pending=%0d inflight=%0d want 0 0", name, sb.size(), InFlightxDO);
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [VW-1:0] ev;
    logic w, iss;
    drive_cycle(1'b1, 1'b0, 1'b1, 8'h53, 8'h00, ev, w, iss);
    chk_cnt++;
    if ({obs_vec(), Req0ReadyxSO} !== {ev, 1'b1})
      $display("FAIL single_issue got %h want %h", {obs_vec(), Req0ReadyxSO}, {ev, 1'b1});
    else pass_cnt++;
    for (int k = 1; k <= LATENCY; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, ev, w, iss);
      chk_cnt++;
      if (k < LATENCY) begin
        if (RspValidxSO !== 1'b0) $display("FAIL single_early cyc=%0d got valid=%b want 0", k, RspValidxSO);
        else pass_cnt++;
      end else begin
        if ({RspValidxSO, RspIdxDO, xor_shares(_RspQxDO)} !== {1'b1, 1'b0, 4'h7})
          $display("FAIL single_result got v=%b id=%b q=%h want v=1 id=0 q=7",
                   RspValidxSO, RspIdxDO, xor_shares(_RspQxDO));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_contention();
    logic [VW-1:0] ev;
    logic w, iss, v;
    logic [3:0] inflight_tbl [4];
    inflight_tbl[0] = 4'd1;
    inflight_tbl[1] = 4'd2;
    inflight_tbl[2] = 4'd3;
    inflight_tbl[3] = 4'd3;
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      v = (k < 4);
      drive_cycle(v, v, v, W'($urandom), W'($urandom), ev, w, iss);
      chk_cnt++;
      if (obs_vec() !== ev) $display("FAIL contention_outputs cyc=%0d got %h want %h", k, obs_vec(), ev);
      else pass_cnt++;
      if (k < 4) begin
        chk_cnt++;
        if ({Req0ReadyxSO, Req1ReadyxSO} !== {~k[0], k[0]})
          $display("FAIL contention_grant cyc=%0d got %b%b want %b%b", k,
                   Req0ReadyxSO, Req1ReadyxSO, ~k[0], k[0]);
        else pass_cnt++;
      end
      if (k >= 1 && k <= 4) begin
        chk_cnt++;
        if (InFlightxDO !== inflight_tbl[k-1])
          $display("FAIL contention_inflight cyc=%0d got %0d want %0d", k, InFlightxDO, inflight_tbl[k-1]);
        else pass_cnt++;
      end
      if (k >= 3 && k <= 6) begin
        chk_cnt++;
        if ({RspValidxSO, RspIdxDO} !== {1'b1, k[0] ^ 1'b1})
          $display("FAIL contention_rsp cyc=%0d got v=%b id=%b want v=1 id=%b", k,
                   RspValidxSO, RspIdxDO, k[0] ^ 1'b1);
        else pass_cnt++;
      end
      if (k >= 7) begin
        chk_cnt++;
        if (InFlightxDO !== 4'd0) $display("FAIL contention_drain cyc=%0d got %0d want 0", k, InFlightxDO);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] ev;
    logic w, iss;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, W'($urandom), W'($urandom), ev, w, iss);
      chk_cnt++;
      if (obs_vec() !== ev) $display("FAIL burst_outputs cyc=%0d got %h want %h", k, obs_vec(), ev);
      else pass_cnt++;
    end
    #1;
    RstxBI = 1'b0;
    #1;
    chk_cnt++;
    if ({obs_vec(), RspValidxSO, RspIdxDO, _RspQxDO} !== {(VW+W+2){1'b0}})
      $display("FAIL reset_mid_outputs got %h want 0", {obs_vec(), RspValidxSO, RspIdxDO, _RspQxDO});
    else pass_cnt++;
    sb.delete();
    m_prio = 1'b0;
    m_tag  = '0;
    clear_inputs();
    @(posedge ClkxCI);
    #1;
    RstxBI = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, ev, w, iss);
      chk_cnt++;
      if ({RspValidxSO, InFlightxDO} !== 5'd0)
        $display("FAIL reset_mid_quiet cyc=%0d got v=%b inflight=%0d want 0 0", k, RspValidxSO, InFlightxDO);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] ev;
    logic w, iss;
    logic         pv [2];
    logic [W-1:0] px [2];
    int issued;
    int bad;
    issued = 0;
    bad    = 0;
    pv[0]  = 1'b0;
    pv[1]  = 1'b0;
    for (int cyc = 0; cyc < 20000 && issued < 1000; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pv[n]) begin
          px[n] = W'($urandom);
          pv[n] = ($urandom_range(0, 3) != 0);
        end
      end
      drive_cycle(pv[0], pv[1], ($urandom_range(0, 3) != 0), px[0], px[1], ev, w, iss);
      chk_cnt++;
      if (obs_vec() !== ev) begin
        bad++;
        if (bad <= 10) $display("FAIL random_outputs cyc=%0d got %h want %h", cyc, obs_vec(), ev);
      end else pass_cnt++;
      if (iss) begin
        pv[w] = 1'b0;
        issued++;
      end
    end
    chk_cnt++;
    if (issued !== 1000) $display("FAIL random_issue_count got %0d want 1000", issued);
    else pass_cnt++;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_starvation();
    test_drain("starve");
    test_single();
    test_contention();
    test_reset_mid();
    test_random();
    test_drain("random");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
